// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between M upstream requesters, the arbiter and the fifo
// write side. The arbiter connects through the slave modport; the upstream
// and fifo side (or a testbench) drives through the master modport.
interface fifo_wr_arbiter_if #(
  parameter int N = 8,
  parameter int M = 3
);
  logic [M-1:0]   S_VALID;
  logic [M-1:0]   S_READY;
  logic [M*N-1:0] S_DATA;
  logic [M-1:0]   S_LAST;
  logic           WVALID;
  logic           WREADY;
  logic [N-1:0]   WDATA;
  logic [M-1:0]   GRANT;
  logic           BUSY;

  modport slave (
    input  S_VALID, S_DATA, S_LAST, WREADY,
    output S_READY, WVALID, WDATA, GRANT, BUSY
  );

  modport master (
    output S_VALID, S_DATA, S_LAST, WREADY,
    input  S_READY, WVALID, WDATA, GRANT, BUSY
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one fifo write port between M
// requesters. The owner keeps the port until its LAST beat is accepted, so
// packets never interleave in the fifo.
module fifo_wr_arbiter #(
  parameter int N = 8,
  parameter int M = 3
) (
  input  logic              clock,
  input  logic              reset,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int PW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   g_q, g_d;
  logic [PW-1:0]   p_q, p_d;
  logic [M-1:0]    grant_q, grant_d;

  logic            found;
  logic [PW-1:0]   win;
  logic            accept_last;

  // Route the owner's beat to the fifo; nothing is presented while idle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and a latch is never inferred.
    bus.WVALID  = 1'b0;
    bus.WDATA   = '0;
    bus.S_READY = '0;
    if (state_q == ST_LOCKED) begin
      bus.WVALID       = bus.S_VALID[g_q];
      bus.WDATA        = bus.S_DATA[g_q*N +: N];
      bus.S_READY[g_q] = bus.WREADY;
    end
  end

  assign accept_last = (state_q == ST_LOCKED) && bus.S_VALID[g_q] &&
                       bus.WREADY && bus.S_LAST[g_q];

  // Rotating search: first valid requester starting at p, wrapping at M.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_w;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < M; k++) begin
      idx = int'(p_q) + k;
      if (idx >= M) idx = idx - M;
      idx_w = idx[PW-1:0];
      if (!found && bus.S_VALID[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  // Re-arbitrate when idle or when the owner's LAST beat is accepted.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    grant_d = grant_q;
    if (state_q == ST_IDLE || accept_last) begin
      if (found) begin
        state_d      = ST_LOCKED;
        g_d          = win;
        p_d          = (win == PW'(M - 1)) ? '0 : win + 1'b1;
        grant_d      = '0;
        grant_d[win] = 1'b1;
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    end
  end

  // Arbitration state register; reset drops the grant without a clock edge.
  // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      p_q     <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      grant_q <= grant_d;
    end
  end

  assign bus.GRANT = grant_q;
  assign bus.BUSY  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (N=8, M=3): a vector table for the
// round-robin packet sequence, hand-written corner sequences, then random
// traffic compared against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

  localparam int N = 8;
  localparam int M = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  fifo_wr_arbiter_if #(.N(N), .M(M)) bus ();

  fifo_wr_arbiter #(.N(N), .M(M)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [M-1:0]   v;
    logic [M-1:0]   l;
    logic           wr;
    logic [M*N-1:0] d;
    logic [M-1:0]   g;
    logic           wv;
    logic [M-1:0]   sr;
    logic [N-1:0]   wd;
    logic           b;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [M-1:0] v, input logic [M-1:0] l,
                       input logic wr, input logic [M*N-1:0] d);
    bus.S_VALID = v;
    bus.S_LAST  = l;
    bus.WREADY  = wr;
    bus.S_DATA  = d;
  endtask

  // Apply inputs just after the falling edge and let the decode settle.
  task automatic tick(input logic [M-1:0] v, input logic [M-1:0] l,
                      input logic wr, input logic [M*N-1:0] d);
    @(negedge clock);
    drive(v, l, wr, d);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [M-1:0] g, input logic wv,
                            input logic [M-1:0] sr, input logic [N-1:0] wd, input logic b);
    check({tag, " grant"},   32'(bus.GRANT),   32'(g));
    check({tag, " wvalid"},  32'(bus.WVALID),  32'(wv));
    check({tag, " s_ready"}, 32'(bus.S_READY), 32'(sr));
    check({tag, " wdata"},   32'(bus.WDATA),   32'(wd));
    check({tag, " busy"},    32'(bus.BUSY),    32'(b));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    drive('0, '0, 1'b0, '0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic vec_t mk(logic [M-1:0] v, logic [M-1:0] l, logic wr, logic [M*N-1:0] d,
                              logic [M-1:0] g, logic wv, logic [M-1:0] sr, logic [N-1:0] wd,
                              logic b);
    vec_t r;
    r.v = v; r.l = l; r.wr = wr; r.d = d;
    r.g = g; r.wv = wv; r.sr = sr; r.wd = wd; r.b = b;
    return r;
  endfunction

  // Behavioural model state and random requester state.
  logic          m_locked;
  int            m_owner;
  int            m_ptr;
  logic [M-1:0]  rq_valid;
  int            rq_rem  [M];
  logic [N-1:0]  rq_data [M];

  initial begin
    drive('1, '0, 1'b1, '0);

    // Reset held low with every requester valid: nothing may be granted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      expect_out("reset_hold", 3'b000, 1'b0, 3'b000, 8'h00, 1'b0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_release grant", 32'(bus.GRANT), 32'(3'b001));

    // All three requesters with 2-beat packets, fifo always ready.
    tbl[0] = mk(3'b111, 3'b000, 1'b1, {8'h20, 8'h10, 8'h00}, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0);
    tbl[1] = mk(3'b111, 3'b000, 1'b1, {8'h20, 8'h10, 8'h00}, 3'b001, 1'b1, 3'b001, 8'h00, 1'b1);
    tbl[2] = mk(3'b111, 3'b001, 1'b1, {8'h20, 8'h10, 8'h01}, 3'b001, 1'b1, 3'b001, 8'h01, 1'b1);
    tbl[3] = mk(3'b110, 3'b000, 1'b1, {8'h20, 8'h10, 8'h00}, 3'b010, 1'b1, 3'b010, 8'h10, 1'b1);
    tbl[4] = mk(3'b110, 3'b010, 1'b1, {8'h20, 8'h11, 8'h00}, 3'b010, 1'b1, 3'b010, 8'h11, 1'b1);
    tbl[5] = mk(3'b100, 3'b000, 1'b1, {8'h20, 8'h11, 8'h00}, 3'b100, 1'b1, 3'b100, 8'h20, 1'b1);
    tbl[6] = mk(3'b100, 3'b100, 1'b1, {8'h21, 8'h11, 8'h00}, 3'b100, 1'b1, 3'b100, 8'h21, 1'b1);
    // Sole requester re-won on its LAST and stays owner while silent.
    tbl[7] = mk(3'b000, 3'b000, 1'b1, {8'h21, 8'h11, 8'h00}, 3'b100, 1'b0, 3'b100, 8'h21, 1'b1);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].v, tbl[i].l, tbl[i].wr, tbl[i].d);
      expect_out($sformatf("rr_vec%0d", i), tbl[i].g, tbl[i].wv, tbl[i].sr, tbl[i].wd, tbl[i].b);
    end

    // Requester 1 four-beat packet with fifo stall; requester 0 arrives mid-packet.
    do_reset();
    tick(3'b010, 3'b000, 1'b1, {8'h00, 8'hB0, 8'h00});
    expect_out("bp_idle", 3'b000, 1'b0, 3'b000, 8'h00, 1'b0);
    tick(3'b010, 3'b000, 1'b1, {8'h00, 8'hB0, 8'h00});
    expect_out("bp_beat0", 3'b010, 1'b1, 3'b010, 8'hB0, 1'b1);
    tick(3'b010, 3'b000, 1'b1, {8'h00, 8'hB1, 8'h00});
    expect_out("bp_beat1", 3'b010, 1'b1, 3'b010, 8'hB1, 1'b1);
    tick(3'b010, 3'b000, 1'b1, {8'h00, 8'hB2, 8'h00});
    expect_out("bp_beat2", 3'b010, 1'b1, 3'b010, 8'hB2, 1'b1);
    tick(3'b011, 3'b010, 1'b0, {8'h00, 8'hB3, 8'hA0});
    expect_out("bp_stall0", 3'b010, 1'b1, 3'b000, 8'hB3, 1'b1);
    tick(3'b011, 3'b010, 1'b0, {8'h00, 8'hB3, 8'hA0});
    expect_out("bp_stall1", 3'b010, 1'b1, 3'b000, 8'hB3, 1'b1);
    tick(3'b011, 3'b010, 1'b1, {8'h00, 8'hB3, 8'hA0});
    expect_out("bp_drain", 3'b010, 1'b1, 3'b010, 8'hB3, 1'b1);
    tick(3'b001, 3'b001, 1'b1, {8'h00, 8'h00, 8'hA0});
    expect_out("bp_next", 3'b001, 1'b1, 3'b001, 8'hA0, 1'b1);

    // Requester 2 alone: three single-beat packets back to back.
    do_reset();
    tick(3'b100, 3'b100, 1'b1, {8'hC1, 8'h00, 8'h00});
    expect_out("sb_idle", 3'b000, 1'b0, 3'b000, 8'h00, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick(3'b100, 3'b100, 1'b1, {8'(8'hC0 + i), 8'h00, 8'h00});
      expect_out($sformatf("sb_pkt%0d", i), 3'b100, 1'b1, 3'b100, 8'(8'hC0 + i), 1'b1);
    end

    // After requester 0 wins (p=1), 0 and 2 contend: 2 first, then 0.
    do_reset();
    tick(3'b001, 3'b001, 1'b1, {8'h00, 8'h00, 8'hD0});
    expect_out("pp_idle", 3'b000, 1'b0, 3'b000, 8'h00, 1'b0);
    tick(3'b101, 3'b001, 1'b1, {8'hE0, 8'h00, 8'hD0});
    expect_out("pp_r0", 3'b001, 1'b1, 3'b001, 8'hD0, 1'b1);
    tick(3'b101, 3'b100, 1'b1, {8'hE0, 8'h00, 8'hD1});
    expect_out("pp_r2", 3'b100, 1'b1, 3'b100, 8'hE0, 1'b1);
    tick(3'b001, 3'b001, 1'b1, {8'hE0, 8'h00, 8'hD1});
    expect_out("pp_r0b", 3'b001, 1'b1, 3'b001, 8'hD1, 1'b1);

    // Asynchronous reset while requester 1 is stalled mid-packet.
    do_reset();
    tick(3'b010, 3'b000, 1'b1, {8'h00, 8'hF0, 8'h00});
    tick(3'b010, 3'b000, 1'b0, {8'h00, 8'hF0, 8'h00});
    expect_out("ar_stalled", 3'b010, 1'b1, 3'b000, 8'hF0, 1'b1);
    #1 reset = 1'b0;
    #1;
    expect_out("ar_async", 3'b000, 1'b0, 3'b000, 8'h00, 1'b0);
    @(negedge clock);
    drive(3'b011, 3'b000, 1'b1, {8'h00, 8'hF0, 8'h0F});
    reset = 1'b1;
    #1;
    expect_out("ar_released", 3'b000, 1'b0, 3'b000, 8'h00, 1'b0);
    tick(3'b011, 3'b000, 1'b1, {8'h00, 8'hF0, 8'h0F});
    expect_out("ar_first", 3'b001, 1'b1, 3'b001, 8'h0F, 1'b1);

    // Random traffic against a model built from the arbitration rules.
    do_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    rq_valid = '0;
    for (int i = 0; i < M; i++) begin
      rq_rem[i]  = 0;
      rq_data[i] = '0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic           wr;
      logic [M*N-1:0] d;
      logic [M-1:0]   l;
      logic [M-1:0]   e_g;
      logic [M-1:0]   e_sr;
      logic           e_wv;
      logic [N-1:0]   e_wd;
      logic           acc;
      logic           acc_last;
      int             best;
      int             bestd;
      int             old_owner;

      for (int i = 0; i < M; i++) begin
        if (!rq_valid[i] && $urandom_range(0, 2) == 0) begin
          if (rq_rem[i] == 0) rq_rem[i] = $urandom_range(1, 4);
          rq_valid[i] = 1'b1;
          rq_data[i]  = 8'($urandom);
        end
      end
      wr = ($urandom_range(0, 3) != 0);
      d  = '0;
      l  = '0;
      for (int i = 0; i < M; i++) begin
        d[i*N +: N] = rq_data[i];
        l[i]        = (rq_rem[i] == 1);
      end
      tick(rq_valid, l, wr, d);

      e_g  = '0;
      e_sr = '0;
      e_wv = 1'b0;
      e_wd = '0;
      if (m_locked) begin
        e_g[m_owner]  = 1'b1;
        e_sr[m_owner] = wr;
        e_wv          = rq_valid[m_owner];
        e_wd          = rq_data[m_owner];
      end
      expect_out($sformatf("rand%0d", cyc), e_g, e_wv, e_sr, e_wd, m_locked);

      old_owner = m_owner;
      acc       = m_locked && rq_valid[m_owner] && wr;
      acc_last  = acc && (rq_rem[m_owner] == 1);
      if (!m_locked || acc_last) begin
        best  = -1;
        bestd = M;
        for (int i = 0; i < M; i++) begin
          if (rq_valid[i] && ((i - m_ptr + M) % M) < bestd) begin
            bestd = (i - m_ptr + M) % M;
            best  = i;
          end
        end
        if (best >= 0) begin
          m_locked = 1'b1;
          m_owner  = best;
          m_ptr    = (best + 1) % M;
        end else begin
          m_locked = 1'b0;
        end
      end
      if (acc) begin
        rq_valid[old_owner] = 1'b0;
        rq_rem[old_owner]   = rq_rem[old_owner] - 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 4-entry `fifo` (WVALID/WREADY/WDATA) between M upstream requesters.
- Grant is packet-locked: once a requester wins, it keeps the port until its LAST beat is accepted, so packets are never interleaved in the FIFO.
- Sits directly in front of the `fifo` write side in the axixfer example datapath.

Parameters:
- N, 8, data width; matches the fifo N.
- M, 3, number of requesters, 2..8.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately, release is synchronous to clock.
- S_VALID  in  M  per-requester beat valid.
- S_READY  out  M  per-requester beat accepted.
- S_DATA  in  M*N  requester i data in bits [i*N +: N].
- S_LAST  in  M  final beat of the packet for requester i.
- WVALID  out  1  to fifo WVALID.
- WREADY  in  1  from fifo WREADY.
- WDATA  out  N  to fifo WDATA.
- GRANT  out  M  registered one-hot owner; 0 when idle.
- BUSY  out  1  registered; 1 while a packet is locked.

Behaviour:
- State: LOCKED flag, grant index g, round-robin pointer p (log2 M bits), all registered.
- Reset (reset low, asynchronous):
  - LOCKED=0, GRANT=0, BUSY=0, p=0 (requester 0 has highest priority).
  - Combinational outputs follow: WVALID=0, S_READY=0.
- Output decode:
  - LOCKED=0: WVALID=0, S_READY=0, WDATA=0.
  - LOCKED=1: WVALID=S_VALID[g], WDATA=S_DATA[g], S_READY[g]=WREADY, all other S_READY bits 0.
- Beat handshake: accepted when WVALID && WREADY, which equals S_VALID[g] && S_READY[g].
- Arbitration event: any clock edge where either
  - (a) LOCKED=0, or
  - (b) a beat with S_LAST[g]=1 is accepted.
- Arbitration rule:
  - Search S_VALID for the first set bit, starting at index p and wrapping modulo M.
  - Winner w: LOCKED<=1, g<=w, GRANT<=1<<w, p<=(w+1) mod M.
  - No valid requester: LOCKED<=0, GRANT<=0, p unchanged.
- In case (b), the finishing requester is a candidate only if no other requester is valid, because p has already moved past it. It may re-win immediately if it is the sole requester.
- Latency:
  - Idle requester asserting S_VALID at edge t sees GRANT and WVALID at edge t+1.
  - First beat can be accepted at edge t+1 if WREADY=1.
  - Back-to-back packets from different requesters have zero bubble cycles.
- Non-LAST accepted beats: no state change.
- Backpressure: WREADY=0 stalls the owner; grant holds indefinitely.
  - Fifo full (WREADY=0) mid-packet does not release the grant.
- Requester obligations, not checked by the arbiter:
  - Once S_VALID[i] is high it stays high, with stable data, until accepted.
  - A requester may deassert S_VALID between beats inside a packet; the grant still holds.
- A single-beat packet (S_LAST=1 on the first beat) locks for exactly one accepted beat.
- Simultaneous requests are resolved purely by p. No requester waits more than M-1 packets.
- Reset asserted mid-packet: grant drops immediately (asynchronous); the partial packet already in the fifo is the upstream's concern.
- No arithmetic beyond a modulo-M pointer increment. For non-power-of-2 M, wrap explicitly: M-1 goes to 0.
- BUSY equals LOCKED.

Test Plan:
- Reset, then hold reset low with all S_VALID=1 → GRANT=0, WVALID=0, S_READY=0 throughout. First edge after release → GRANT=3'b001.
- M=3; all three valid with 2-beat packets, WREADY=1 → grants 001,001,010,010,100,100 on consecutive cycles. WDATA carries each requester's data in order, with no idle cycle between packets.
- Requester 1 alone sends a 4-beat packet while the fifo fills (WREADY=0 after 3 writes) → GRANT stays 010 and S_READY[1]=0 while stalled. The beat completes when the read side drains one entry. Requester 0 asserting valid mid-packet is not granted until after requester 1's LAST.
- Requester 2 alone sends three 1-beat packets back-to-back → GRANT=100 on three consecutive accepted beats, with no bubble and no gap.
- After requester 0 wins (p=1), requesters 0 and 2 both valid → requester 2 granted next, then requester 0.
- Assert reset low while GRANT=010 and a beat is stalled (WREADY=0) → GRANT=0, WVALID=0 with no clock edge. After release with S_VALID=3'b011 → requester 0 is granted first.
